// File: rtl/servant_reset_seq.sv
// servant_reset_seq: staged SoC reset sequencer.
// Waits for a qualified clock lock, holds both resets, then releases the
// peripherals ahead of the core. Records the cause of the last reset and
// accepts software reset requests while running.
module servant_reset_seq #(
  parameter int LOCK_CYCLES = 16,
  parameter int HOLD_CYCLES = 64,
  parameter int GAP_CYCLES  = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_locked,
  input  logic       i_sw_rst_req,
  output logic       o_sw_rst_ack,
  output logic       o_rst_periph,
  output logic       o_rst_core,
  output logic       o_ready,
  output logic [1:0] o_rst_cause
);

  // The shared counter must be able to hold the largest phase length.
  localparam int MAX_LH = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int MAX_P  = (MAX_LH > GAP_CYCLES) ? MAX_LH : GAP_CYCLES;
  localparam int CW     = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_LOCK = 2'b10;
  localparam logic [1:0] CAUSE_SW   = 2'b11;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    PERIPH    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    lockSync_q;
  logic          lockS;
  logic [1:0]    cause_q, cause_d;
  logic          ack_q, ack_d;
  logic          rstPeriph_q, rstPeriph_d;
  logic          rstCore_q, rstCore_d;
  logic          ready_q, ready_d;

  assign lockS = lockSync_q[1];

  // Two-flop synchroniser bringing the asynchronous lock into i_clk.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) lockSync_q <= 2'b00;
    else       lockSync_q <= {lockSync_q[0], i_pll_locked};
  end

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ack_d   = 1'b0;
    cnt_d   = cnt_q + CW'(1);

    unique case (state_q)
      WAIT_LOCK: begin
        if (!lockS) cnt_d = '0;
        else if (cnt_q == LOCK_LAST) state_d = HOLD;
      end
      HOLD: begin
        if (!lockS) begin
          state_d = WAIT_LOCK;
          cause_d = CAUSE_LOCK;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = PERIPH;
        end
      end
      PERIPH: begin
        if (!lockS) begin
          state_d = WAIT_LOCK;
          cause_d = CAUSE_LOCK;
        end else if (cnt_q == GAP_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (!lockS) begin
          state_d = WAIT_LOCK;
          cause_d = CAUSE_LOCK;
        end else if (i_sw_rst_req) begin
          state_d = HOLD;
          cause_d = CAUSE_SW;
          ack_d   = 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase

    if (state_d != state_q) cnt_d = '0;

    rstPeriph_d = (state_d == WAIT_LOCK) || (state_d == HOLD);
    rstCore_d   = (state_d != RUN);
    ready_d     = (state_d == RUN);
  end

  // State, counter, cause and output registers; outputs track the next state
  // so each phase change is visible on the same edge that enters it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= WAIT_LOCK;
      cnt_q       <= '0;
      cause_q     <= CAUSE_EXT;
      ack_q       <= 1'b0;
      rstPeriph_q <= 1'b1;
      rstCore_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      ack_q       <= ack_d;
      rstPeriph_q <= rstPeriph_d;
      rstCore_q   <= rstCore_d;
      ready_q     <= ready_d;
    end
  end

  assign o_sw_rst_ack = ack_q;
  assign o_rst_periph = rstPeriph_q;
  assign o_rst_core   = rstCore_q;
  assign o_ready      = ready_q;
  assign o_rst_cause  = cause_q;

endmodule

// File: tb/tb_servant_reset_seq.sv
// tb_servant_reset_seq: directed vectors for the staged reset sequencer.
module tb_servant_reset_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       lock;
  logic       req;
  logic       ack;
  logic       rstPeriph;
  logic       rstCore;
  logic       ready;
  logic [1:0] cause;

  int vectors     = 0;
  int miscompares = 0;
  int edgeNo      = 0;
  int n;
  logic ackSeen;

  typedef struct {
    int         atEdge;
    logic       lock;
    logic       req;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[12];

  servant_reset_seq dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_pll_locked (lock),
    .i_sw_rst_req (req),
    .o_sw_rst_ack (ack),
    .o_rst_periph (rstPeriph),
    .o_rst_core   (rstCore),
    .o_ready      (ready),
    .o_rst_cause  (cause)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Latch any acknowledge pulse so ignored-request windows can be checked.
  always @(negedge clk) begin
    if (ack) ackSeen = 1'b1;
  end

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic stepEdges(input int cnt);
    repeat (cnt) @(posedge clk);
    #1;
    edgeNo += cnt;
  endtask

  task automatic applyStimulus(input logic l, input logic r, input int cnt);
    lock = l;
    req  = r;
    stepEdges(cnt);
  endtask

  // Compare {periph, core, ready, ack, cause} against the expected pattern.
  task automatic checkOutput(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {rstPeriph, rstCore, ready, ack, cause};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got periph/core/ready/ack/cause=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic compareInt(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Edges until o_rst_periph falls, or -1 if it never does within the budget.
  task automatic waitPeriphFall(output int cnt);
    cnt = -1;
    for (int i = 1; i <= 300; i++) begin
      stepEdges(1);
      if (rstPeriph == 1'b0) begin
        cnt = i;
        break;
      end
    end
  endtask

  initial begin
    // exp = {periph, core, ready, ack, cause}
    vecs[0]  = '{0,   1'b1, 1'b0, 6'b110001};
    vecs[1]  = '{81,  1'b1, 1'b0, 6'b110001};
    vecs[2]  = '{82,  1'b1, 1'b0, 6'b010001};
    vecs[3]  = '{89,  1'b1, 1'b0, 6'b010001};
    vecs[4]  = '{90,  1'b1, 1'b0, 6'b001001};
    vecs[5]  = '{100, 1'b1, 1'b0, 6'b001001};
    vecs[6]  = '{101, 1'b1, 1'b1, 6'b110111};
    vecs[7]  = '{102, 1'b1, 1'b0, 6'b110011};
    vecs[8]  = '{164, 1'b1, 1'b0, 6'b110011};
    vecs[9]  = '{165, 1'b1, 1'b0, 6'b010011};
    vecs[10] = '{172, 1'b1, 1'b0, 6'b010011};
    vecs[11] = '{173, 1'b1, 1'b0, 6'b001011};

    rst  = 1'b1;
    lock = 1'b1;
    req  = 1'b0;
    ackSeen = 1'b0;
    stepEdges(3);
    checkOutput("inReset", 6'b110001);
    rst = 1'b0;
    edgeNo = 0;

    // Power-up sequence followed by a one-cycle software request.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].lock, vecs[i].req, vecs[i].atEdge - edgeNo);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Lock loss in RUN: resets rise on the third edge, then full re-sequence.
    $display("[TB] lock loss in RUN");
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("lossEdge2", 6'b001011);
    stepEdges(1);
    checkOutput("lossEdge3", 6'b110010);
    stepEdges(5);
    lock = 1'b1;
    waitPeriphFall(n);
    compareInt("relockPeriphEdge", n, 82);
    stepEdges(7);
    checkOutput("relockCoreHeld", 6'b010010);
    stepEdges(1);
    checkOutput("relockRun", 6'b001010);

    // Lock loss and software request seen in the same RUN cycle.
    $display("[TB] lock loss with simultaneous request");
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("lossPlusReq", 6'b110010);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("lossPlusReqNoAck", 6'b110010);
    lock = 1'b1;
    waitPeriphFall(n);
    compareInt("lossPlusReqRelock", n, 82);
    stepEdges(8);
    checkOutput("lossPlusReqRun", 6'b001010);

    // Async reset in the middle of PERIPH.
    $display("[TB] async reset in PERIPH");
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("swAck2", 6'b110111);
    applyStimulus(1'b1, 1'b0, 64);
    checkOutput("inPeriph", 6'b010011);
    #3 rst = 1'b1;
    #1 checkOutput("asyncRst", 6'b110001);
    stepEdges(2);
    checkOutput("asyncRstHeld", 6'b110001);
    rst = 1'b0;
    waitPeriphFall(n);
    compareInt("afterRstPeriph", n, 82);
    stepEdges(8);
    checkOutput("afterRstRun", 6'b001001);

    // Lock glitch during WAIT_LOCK while a request is held (must be ignored).
    $display("[TB] lock glitch in WAIT_LOCK");
    rst  = 1'b1;
    lock = 1'b0;
    stepEdges(2);
    rst = 1'b0;
    ackSeen = 1'b0;
    applyStimulus(1'b1, 1'b1, 10);
    applyStimulus(1'b0, 1'b1, 1);
    lock = 1'b1;
    waitPeriphFall(n);
    compareInt("glitchRelock", n, 82);
    req = 1'b0;
    compareInt("ignoredReqAck", int'(ackSeen), 0);
    stepEdges(8);
    checkOutput("glitchRun", 6'b001001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
